// File: rtl/button_debounce.sv
// ============================================================================
// button_debounce
// ----------------------------------------------------------------------------
// Debounces a mechanical pushbutton and reports what the user did with it.
// The raw pin is first put into "1 = pressed" form and passed through a
// two-flop synchroniser. A four-state FSM then accepts a level change only
// after the synchronised input has stayed at the new level for
// DEBOUNCE_CYCLES consecutive cycles.
//
// Optional feature (compile-time macro):
//   BTN_LONG_PRESS_EN  When defined, a hold counter raises long_press for one
//                      cycle once the button has been held for LONG_CYCLES
//                      cycles after an accepted press. When undefined, the hold
//                      counter does not exist and long_press is tied to 0.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a press or release
//                    (1 .. 2**26-1)
//   LONG_CYCLES      held cycles after an accepted press that make a long
//                    press (1 .. 2**26-1)
//   BTN_ACTIVE_LOW   1: a raw 0 means pressed, 0: a raw 1 means pressed
//
// Ports:
//   clk            single clock; all logic runs in this domain
//   rst            asynchronous, active-high reset
//   btn_raw        asynchronous pushbutton pin
//   btn_level      debounced button state, 1 = pressed
//   press_pulse    one-cycle strobe when a press is accepted
//   release_pulse  one-cycle strobe when a release is accepted
//   long_press     one-cycle strobe when a long press is detected
//   press_count    count of accepted presses; wraps from 255 to 0
//
// Latency: a clean press raises press_pulse after the DEBOUNCE_CYCLES+3rd
// clock edge, counting the first edge that samples btn_raw pressed as edge 1
// (two synchroniser edges, one edge to arm, DEBOUNCE_CYCLES edges of
// qualification). A release has the same latency.
// ============================================================================
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press,
    output logic [7:0] press_count
);

    // Debounce counter value that completes qualification of a new level.
    localparam logic [25:0] DEB_LAST = 26'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM_PRESS,
        DOWN,
        ARM_RELEASE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [25:0] r_cnt;
    logic [25:0] w_cnt_next;
    logic        r_sync1;
    logic        r_sync2;
    logic        w_btn_pressed;
    logic        w_level_next;
    logic        w_press_next;
    logic        w_release_next;
    logic [7:0]  w_count_next;

    // Normalise polarity before synchronising, so the synchroniser resets to
    // "not pressed" whatever the board wiring is.
    assign w_btn_pressed = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;

    // Two-flop synchroniser; only r_sync2 is ever looked at by the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= w_btn_pressed;
            r_sync2 <= r_sync1;
        end
    end

    // State register plus the registered outputs. The pulses are registered
    // so each one is clean and exactly one cycle wide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= 26'd0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            btn_level     <= w_level_next;
            press_pulse   <= w_press_next;
            release_pulse <= w_release_next;
            press_count   <= w_count_next;
        end
    end

    // Next-state logic. The ARM states qualify a candidate level change: any
    // return of the input to the old level during qualification drops back to
    // the settled state with no pulse, which is what rejects contact bounce.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_level_next   = btn_level;
        w_press_next   = 1'b0;
        w_release_next = 1'b0;
        w_count_next   = press_count;

        case (r_state)
            IDLE: begin
                w_cnt_next = 26'd0;
                if (r_sync2) begin
                    w_state_next = ARM_PRESS;
                end
            end

            ARM_PRESS: begin
                if (!r_sync2) begin
                    w_state_next = IDLE;
                    w_cnt_next   = 26'd0;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_next = DOWN;
                    w_cnt_next   = 26'd0;
                    w_level_next = 1'b1;
                    w_press_next = 1'b1;
                    // 8-bit counter wraps 255 -> 0 naturally.
                    w_count_next = press_count + 8'd1;
                end else begin
                    w_cnt_next = r_cnt + 26'd1;
                end
            end

            DOWN: begin
                w_cnt_next = 26'd0;
                if (!r_sync2) begin
                    w_state_next = ARM_RELEASE;
                end
            end

            ARM_RELEASE: begin
                if (r_sync2) begin
                    w_state_next = DOWN;
                    w_cnt_next   = 26'd0;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_next   = IDLE;
                    w_cnt_next     = 26'd0;
                    w_level_next   = 1'b0;
                    w_release_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 26'd1;
                end
            end

            default: begin
                w_state_next = IDLE;
                w_cnt_next   = 26'd0;
            end
        endcase
    end

`ifdef BTN_LONG_PRESS_EN
    // Hold counter fires at LONG_CYCLES-1 and then parks at LONG_CYCLES, so
    // the compare can only match once per accepted press.
    localparam logic [25:0] HOLD_FIRE = 26'(LONG_CYCLES - 1);
    localparam logic [25:0] HOLD_SAT  = 26'(LONG_CYCLES);

    logic [25:0] r_hold;
    logic        w_holding;

    assign w_holding = (r_state == DOWN) || (r_state == ARM_RELEASE);

    // Clearing on the cycle that enters IDLE also keeps long_press from
    // landing in the same cycle as release_pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold     <= 26'd0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (w_state_next == IDLE) begin
                r_hold <= 26'd0;
            end else if (w_holding) begin
                if (r_hold != HOLD_SAT) begin
                    r_hold <= r_hold + 26'd1;
                end
                long_press <= (r_hold == HOLD_FIRE);
            end
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule
